// File: rtl/fifo_pkg.sv
// Shared helpers for the single-clock programmable FIFO.
// Depth/width helpers and the occupancy flag compare.
package fifo_pkg;

  function automatic int unsigned depth_f(int unsigned a);
    return 32'd1 << a;
  endfunction

  function automatic int unsigned cnt_w_f(int unsigned a);
    return a + 32'd1;
  endfunction

  typedef struct packed {
    logic full;
    logic half_full;
    logic almost_full;
    logic empty;
    logic half_empty;
    logic almost_empty;
  } flags_t;

  function automatic flags_t flags_f(
    int unsigned cnt,
    int unsigned depth,
    int unsigned af,
    int unsigned ae
  );
    flags_t f;
    f.full         = (cnt == depth);
    f.half_full    = (cnt >= depth / 2);
    f.almost_full  = (cnt >= af);
    f.empty        = (cnt == 0);
    f.half_empty   = (cnt <= depth / 2);
    f.almost_empty = (cnt <= ae);
    return f;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Dual-port storage array for sync_fifo_prog.
// One write port, one registered read port, no reset.
module sync_fifo_mem #(
  parameter int unsigned D_SIZE = 8,
  parameter int unsigned A_SIZE = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [A_SIZE-1:0] waddr_i,
  input  logic [D_SIZE-1:0] wdata_i,
  input  logic              re_i,
  input  logic [A_SIZE-1:0] raddr_i,
  output logic [D_SIZE-1:0] rdata_o
);

  logic [D_SIZE-1:0] mem_q [2**A_SIZE];
  logic [D_SIZE-1:0] rdata_q;

  // Write on accept; read data registered on accept, held otherwise.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable thresholds and count.
// Sticky overflow/underflow, flush, registered read data.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int unsigned D_SIZE = 8,
  parameter int unsigned A_SIZE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [D_SIZE-1:0] w_data,
  input  logic              w_inc,
  output logic              w_full,
  output logic              w_half_full,
  output logic              w_almost_full,
  input  logic [A_SIZE:0]   w_af_thresh,
  input  logic              r_inc,
  output logic [D_SIZE-1:0] r_data,
  output logic              r_valid,
  output logic              r_empty,
  output logic              r_half_empty,
  output logic              r_almost_empty,
  input  logic [A_SIZE:0]   r_ae_thresh,
  output logic [A_SIZE:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned DEPTH = depth_f(A_SIZE);
  localparam int unsigned PW    = cnt_w_f(A_SIZE);

  localparam logic [PW-1:0] ONE = {{A_SIZE{1'b0}}, 1'b1};

  logic [PW-1:0]     w_ptr_q, w_ptr_d;
  logic [PW-1:0]     r_ptr_q, r_ptr_d;
  logic [PW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              vld_q, vld_d;
  logic              seen_q, seen_d;
  logic              we, re;
  logic [D_SIZE-1:0] mem_rdata;
  flags_t            flg;

  // Occupancy flags from the registered count and live thresholds.
  always_comb begin
    flg = flags_f(32'(cnt_q), DEPTH,
                  32'(w_af_thresh), 32'(r_ae_thresh));
  end

  assign we = w_inc && !flg.full && !flush;
  assign re = r_inc && !flg.empty && !flush;

  // Next-state for pointers, count and error flags.
  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    vld_d   = re;
    seen_d  = seen_q | re;
    if (flush) begin
      w_ptr_d = '0;
      r_ptr_d = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      if (we) w_ptr_d = w_ptr_q + ONE;
      if (re) r_ptr_d = r_ptr_q + ONE;
      unique case ({we, re})
        2'b10:   cnt_d = cnt_q + ONE;
        2'b01:   cnt_d = cnt_q - ONE;
        default: cnt_d = cnt_q;
      endcase
      if (w_inc && flg.full)  ovf_d = 1'b1;
      if (r_inc && flg.empty) udf_d = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      vld_q   <= 1'b0;
      seen_q  <= 1'b0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      vld_q   <= vld_d;
      seen_q  <= seen_d;
    end
  end

  sync_fifo_mem #(
    .D_SIZE (D_SIZE),
    .A_SIZE (A_SIZE)
  ) u_mem (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (w_ptr_q[A_SIZE-1:0]),
    .wdata_i (w_data),
    .re_i    (re),
    .raddr_i (r_ptr_q[A_SIZE-1:0]),
    .rdata_o (mem_rdata)
  );

  // The array has no reset, so r_data reads as zero until the
  // first accepted read after rst.
  assign r_data         = seen_q ? mem_rdata : '0;
  assign r_valid        = vld_q;
  assign w_full         = flg.full;
  assign w_half_full    = flg.half_full;
  assign w_almost_full  = flg.almost_full;
  assign r_empty        = flg.empty;
  assign r_half_empty   = flg.half_empty;
  assign r_almost_empty = flg.almost_empty;
  assign count          = cnt_q;
  assign overflow       = ovf_q;
  assign underflow      = udf_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Self-checking bench for sync_fifo_prog.
// Queue reference model plus vector table and directed cases.
module tb_sync_fifo_prog;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst, flush, w_inc, r_inc;
  logic [DW-1:0] w_data;
  logic [AW:0]   w_af_thresh, r_ae_thresh;
  logic          w_full, w_half_full, w_almost_full;
  logic [DW-1:0] r_data;
  logic          r_valid, r_empty, r_half_empty, r_almost_empty;
  logic [AW:0]   count;
  logic          overflow, underflow;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mq[$];
  bit            m_ovf, m_udf, m_vld;
  logic [DW-1:0] m_rdata;

  typedef struct {
    bit       rs, fl, w, r;
    int       data;
    int       e_count, e_vld, e_rdata, e_ovf, e_udf;
  } vec_t;

  vec_t tv[9];

  sync_fifo_prog #(.D_SIZE(DW), .A_SIZE(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .w_data         (w_data),
    .w_inc          (w_inc),
    .w_full         (w_full),
    .w_half_full    (w_half_full),
    .w_almost_full  (w_almost_full),
    .w_af_thresh    (w_af_thresh),
    .r_inc          (r_inc),
    .r_data         (r_data),
    .r_valid        (r_valid),
    .r_empty        (r_empty),
    .r_half_empty   (r_half_empty),
    .r_almost_empty (r_almost_empty),
    .r_ae_thresh    (r_ae_thresh),
    .count          (count),
    .overflow       (overflow),
    .underflow      (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_edge();
    int  n;
    bit  mfull, mempty;
    n      = mq.size();
    mfull  = (n == DEPTH);
    mempty = (n == 0);
    if (rst) begin
      mq.delete();
      m_ovf = 0; m_udf = 0; m_vld = 0; m_rdata = '0;
    end else if (flush) begin
      mq.delete();
      m_ovf = 0; m_udf = 0; m_vld = 0;
    end else begin
      m_vld = r_inc && !mempty;
      if (m_vld) m_rdata = mq.pop_front();
      if (w_inc && !mfull) mq.push_back(w_data);
      if (w_inc && mfull) m_ovf = 1;
      if (r_inc && mempty) m_udf = 1;
    end
  endtask

  task automatic compare_model();
    int n;
    n = mq.size();
    chk("m_count", int'(count), n);
    chk("m_full", int'(w_full), int'(n == DEPTH));
    chk("m_hfull", int'(w_half_full), int'(n >= DEPTH / 2));
    chk("m_afull", int'(w_almost_full), int'(n >= int'(w_af_thresh)));
    chk("m_empty", int'(r_empty), int'(n == 0));
    chk("m_hempty", int'(r_half_empty), int'(n <= DEPTH / 2));
    chk("m_aempty", int'(r_almost_empty), int'(n <= int'(r_ae_thresh)));
    chk("m_valid", int'(r_valid), int'(m_vld));
    chk("m_rdata", int'(r_data), int'(m_rdata));
    chk("m_ovf", int'(overflow), int'(m_ovf));
    chk("m_udf", int'(underflow), int'(m_udf));
  endtask

  task automatic step(bit rs, bit fl, bit w, bit r, int d);
    rst = rs; flush = fl; w_inc = w; r_inc = r;
    w_data = DW'(d);
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
    rst = 0; flush = 0; w_inc = 0; r_inc = 0;
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; flush = 0; w_inc = 0; r_inc = 0; w_data = '0;
    w_af_thresh = 5'd12; r_ae_thresh = 5'd3;
    #1;
    do_reset();

    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(r_empty), 1);
    chk("rst_full", int'(w_full), 0);
    chk("rst_hempty", int'(r_half_empty), 1);
    chk("rst_hfull", int'(w_half_full), 0);
    chk("rst_valid", int'(r_valid), 0);
    chk("rst_rdata", int'(r_data), 0);

    tv[0] = '{0, 0, 1, 0, 'h11, 1, 0, 'h00, 0, 0};
    tv[1] = '{0, 0, 1, 0, 'h22, 2, 0, 'h00, 0, 0};
    tv[2] = '{0, 0, 0, 1, 'h00, 1, 1, 'h11, 0, 0};
    tv[3] = '{0, 0, 1, 1, 'h33, 1, 1, 'h22, 0, 0};
    tv[4] = '{0, 0, 0, 1, 'h00, 0, 1, 'h33, 0, 0};
    tv[5] = '{0, 0, 0, 1, 'h00, 0, 0, 'h33, 0, 1};
    tv[6] = '{0, 0, 1, 1, 'h44, 1, 0, 'h33, 0, 1};
    tv[7] = '{0, 1, 1, 0, 'h99, 0, 0, 'h33, 0, 0};
    tv[8] = '{0, 0, 0, 0, 'h00, 0, 0, 'h33, 0, 0};
    for (int i = 0; i < 9; i++) begin
      step(tv[i].rs, tv[i].fl, tv[i].w, tv[i].r, tv[i].data);
      chk($sformatf("tv%0d_count", i), int'(count), tv[i].e_count);
      chk($sformatf("tv%0d_valid", i), int'(r_valid), tv[i].e_vld);
      chk($sformatf("tv%0d_rdata", i), int'(r_data), tv[i].e_rdata);
      chk($sformatf("tv%0d_ovf", i), int'(overflow), tv[i].e_ovf);
      chk($sformatf("tv%0d_udf", i), int'(underflow), tv[i].e_udf);
    end

    // Fill and drain.
    do_reset();
    for (int i = 0; i < 16; i++) step(0, 0, 1, 0, i);
    chk("fill_full", int'(w_full), 1);
    chk("fill_count", int'(count), 16);
    w_af_thresh = 5'd17; r_ae_thresh = 5'd16;
    #1;
    chk("af_above_depth", int'(w_almost_full), 0);
    chk("ae_at_depth", int'(r_almost_empty), 1);
    w_af_thresh = 5'd12; r_ae_thresh = 5'd3;
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 0, 1, 0);
      chk("drain_valid", int'(r_valid), 1);
      chk("drain_data", int'(r_data), i);
    end
    chk("drain_empty", int'(r_empty), 1);

    // Thresholds.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 1, 0, 100 + i);
      if (i == 10) chk("af_before", int'(w_almost_full), 0);
    end
    chk("af_rise", int'(w_almost_full), 1);
    chk("hf_at12", int'(w_half_full), 1);
    for (int i = 0; i < 9; i++) begin
      step(0, 0, 0, 1, 0);
      if (i == 7) chk("ae_at4", int'(r_almost_empty), 0);
    end
    chk("ae_count", int'(count), 3);
    chk("ae_at3", int'(r_almost_empty), 1);

    // Boundaries: both requests at full, then at empty.
    do_reset();
    for (int i = 0; i < 16; i++) step(0, 0, 1, 0, i);
    step(0, 0, 1, 1, 'hAA);
    chk("bf_count", int'(count), 15);
    chk("bf_ovf", int'(overflow), 1);
    chk("bf_rdata", int'(r_data), 0);
    for (int i = 0; i < 15; i++) begin
      step(0, 0, 0, 1, 0);
      chk("bf_noAA", int'(r_data), i + 1);
    end
    step(0, 0, 1, 1, 'h55);
    chk("be_count", int'(count), 1);
    chk("be_udf", int'(underflow), 1);
    chk("be_valid", int'(r_valid), 0);
    step(0, 0, 0, 1, 0);
    chk("be_read55", int'(r_data), 'h55);
    chk("be_valid2", int'(r_valid), 1);

    // Wrap-around with steady occupancy.
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 200 + i);
    for (int i = 0; i < 40; i++) step(0, 0, 1, 1, $urandom_range(0, 255));
    chk("wrap_count", int'(count), 5);
    chk("wrap_ovf", int'(overflow), 0);
    chk("wrap_udf", int'(underflow), 0);

    // Flush overrides a write; then rst together with flush.
    do_reset();
    for (int i = 0; i < 17; i++) step(0, 0, 1, 0, i);
    for (int i = 0; i < 9; i++) step(0, 0, 0, 1, 0);
    chk("fl_pre_count", int'(count), 7);
    chk("fl_pre_ovf", int'(overflow), 1);
    step(0, 1, 1, 0, 'hEE);
    chk("fl_count", int'(count), 0);
    chk("fl_empty", int'(r_empty), 1);
    chk("fl_ovf", int'(overflow), 0);
    chk("fl_rdata_hold", int'(r_data), 8);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 0, i);
    step(0, 0, 0, 1, 0);
    step(1, 1, 1, 1, 0);
    chk("rf_count", int'(count), 0);
    chk("rf_rdata", int'(r_data), 0);
    chk("rf_valid", int'(r_valid), 0);
    chk("rf_empty", int'(r_empty), 1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        w_af_thresh = 5'($urandom_range(0, 18));
        r_ae_thresh = 5'($urandom_range(0, 18));
      end
      step(0, $urandom_range(0, 40) == 0,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 255));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
